// File: rtl/fpu_pkg.sv
// Shared widths, constants and state encoding for the FP result packer.
// Build option FPU_SUBNORMAL_EN: when defined, underflowing results are
// denormalized and packed as subnormals instead of being flushed to zero.
package fpu_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned MANT_X_W = 28;
    localparam int unsigned XEXP_W   = 10;
    localparam int unsigned GRS_W    = 3;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned BIAS     = 127;
    localparam int unsigned EXP_MAX  = 255;

    localparam logic [WORD_W-1:0] QNAN = 32'h7FC0_0000;

    localparam logic signed [XEXP_W-1:0] EXP_ONE = XEXP_W'(1);
    localparam logic signed [XEXP_W-1:0] EXP_OVF = XEXP_W'(EXP_MAX);

`ifdef FPU_SUBNORMAL_EN
    localparam bit SUBNORMAL_EN = 1'b1;
`else
    localparam bit SUBNORMAL_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } packer_state_t;

    // Right shift needed: carry set, or (subnormal build) exponent below 1.
    function automatic logic needs_rshift(input logic [MANT_X_W-1:0]     m,
                                          input logic signed [XEXP_W-1:0] e);
        return m[MANT_X_W-1] || (SUBNORMAL_EN && (e < EXP_ONE));
    endfunction

    // Left shift needed: hidden bit clear and exponent still above 1.
    function automatic logic needs_lshift(input logic [MANT_X_W-1:0]     m,
                                          input logic signed [XEXP_W-1:0] e);
        return !m[MANT_X_W-2] && (e > EXP_ONE);
    endfunction

endpackage

// File: rtl/fp_rounder.sv
// Combinational round-to-nearest-even on the hidden+fraction field.
// A carry out means the value rounded up to 2.0; the returned fraction is
// already re-normalized (all zeros) in that case.
module fp_rounder
    import fpu_pkg::*;
(
    input  logic [MANT_X_W-2:0] mant_i,
    output logic [FRAC_W-1:0]   frac_o,
    output logic                hidden_o,
    output logic                carry_o
);

    logic              round_up;
    logic [FRAC_W+1:0] sum;

    // Increment when guard is set and round, sticky or LSB breaks the tie upward.
    always_comb begin
        round_up = mant_i[2] & (mant_i[1] | mant_i[0] | mant_i[3]);
        sum      = {1'b0, mant_i[MANT_X_W-2:GRS_W]} + (FRAC_W+2)'(round_up);
        carry_o  = sum[FRAC_W+1];
        hidden_o = sum[FRAC_W+1] | sum[FRAC_W];
        frac_o   = sum[FRAC_W-1:0];
    end

endmodule

// File: rtl/fp_packer.sv
// Normalizes, rounds (nearest-even) and packs an extended FP result into an
// IEEE-754 single-precision word, one normalization shift per cycle.
// Build option FPU_SUBNORMAL_EN selects subnormal packing over flush-to-zero.
module fp_packer
    import fpu_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                data_valid_i,
    input  logic                sign_i,
    input  logic [XEXP_W-1:0]   exp_i,
    input  logic [MANT_X_W-1:0] mant_i,
    input  logic                infinity_i,
    input  logic                nan_i,
    output logic                data_ready_o,
    output logic                busy_o,
    output logic [WORD_W-1:0]   z_o,
    output logic                z_infinity_o,
    output logic                z_nan_o
);

    packer_state_t state_q, state_d;

    logic                     sign_q, sign_d;
    logic                     nan_q, nan_d;
    logic                     inf_q, inf_d;
    logic signed [XEXP_W-1:0] exp_q, exp_d;
    logic signed [XEXP_W-1:0] exp_r;
    logic [MANT_X_W-1:0]      mant_q, mant_d;
    logic [WORD_W-1:0]        z_q, z_d;
    logic                     zinf_q, zinf_d;
    logic                     znan_q, znan_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;

    logic [FRAC_W-1:0]        rnd_frac;
    logic                     rnd_hidden;
    logic                     rnd_carry;

    fp_rounder u_rounder (
        .mant_i   (mant_q[MANT_X_W-2:0]),
        .frac_o   (rnd_frac),
        .hidden_o (rnd_hidden),
        .carry_o  (rnd_carry)
    );

    // State and datapath registers; synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            z_q     <= '0;
            zinf_q  <= 1'b0;
            znan_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            nan_q   <= nan_d;
            inf_q   <= inf_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            z_q     <= z_d;
            zinf_q  <= zinf_d;
            znan_q  <= znan_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, datapath step and registered output decisions.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        nan_d   = nan_q;
        inf_d   = inf_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        z_d     = z_q;
        zinf_d  = zinf_q;
        znan_d  = znan_q;
        ready_d = 1'b0;
        exp_r   = rnd_carry ? exp_q + EXP_ONE : exp_q;

        case (state_q)
            ST_IDLE: begin
                if (data_valid_i) begin
                    sign_d  = sign_i;
                    nan_d   = nan_i;
                    inf_d   = infinity_i;
                    exp_d   = $signed(exp_i);
                    mant_d  = mant_i;
                    zinf_d  = 1'b0;
                    znan_d  = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (nan_q) begin
                    z_d     = QNAN;
                    znan_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (inf_q) begin
                    z_d     = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    zinf_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (mant_q == '0) begin
                    z_d     = {sign_q, {(WORD_W-1){1'b0}}};
                    state_d = ST_DONE;
                end else if (needs_rshift(mant_q, exp_q) || needs_lshift(mant_q, exp_q)) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_NORM: begin
                // Only entered when a shift is due; leave as soon as none remains.
                if (needs_rshift(mant_q, exp_q)) begin
                    mant_d = {1'b0, mant_q[MANT_X_W-1:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + EXP_ONE;
                end else begin
                    mant_d = {mant_q[MANT_X_W-2:0], 1'b0};
                    exp_d  = exp_q - EXP_ONE;
                end
                if (!needs_rshift(mant_d, exp_d) && !needs_lshift(mant_d, exp_d)) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (exp_r >= EXP_OVF) begin
                    z_d    = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    zinf_d = 1'b1;
                end else if ((exp_r < EXP_ONE) || !mant_q[MANT_X_W-2]) begin
                    // A subnormal that rounds up into the hidden bit becomes the
                    // smallest normal, so the hidden bit lands in the exponent LSB.
                    if (SUBNORMAL_EN) begin
                        z_d = {sign_q, {(EXP_W-1){1'b0}}, rnd_hidden, rnd_frac};
                    end else begin
                        z_d = {sign_q, {(WORD_W-1){1'b0}}};
                    end
                end else begin
                    z_d = {sign_q, exp_r[EXP_W-1:0], rnd_frac};
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign data_ready_o = ready_q;
    assign busy_o       = busy_q;
    assign z_o          = z_q;
    assign z_infinity_o = zinf_q;
    assign z_nan_o      = znan_q;

endmodule

// File: tb/tb_fp_packer.sv
// Testbench for fp_packer: directed cases with known results plus randomized
// requests checked against an arithmetic reference model.
module tb_fp_packer;

`ifdef FPU_SUBNORMAL_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        data_valid_i = 1'b0;
    logic        sign_i = 1'b0;
    logic [9:0]  exp_i = '0;
    logic [27:0] mant_i = '0;
    logic        infinity_i = 1'b0;
    logic        nan_i = 1'b0;
    logic        data_ready_o;
    logic        busy_o;
    logic [31:0] z_o;
    logic        z_infinity_o;
    logic        z_nan_o;

    int n_vec = 0;
    int n_err = 0;

    fp_packer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_valid_i (data_valid_i),
        .sign_i       (sign_i),
        .exp_i        (exp_i),
        .mant_i       (mant_i),
        .infinity_i   (infinity_i),
        .nan_i        (nan_i),
        .data_ready_o (data_ready_o),
        .busy_o       (busy_o),
        .z_o          (z_o),
        .z_infinity_o (z_infinity_o),
        .z_nan_o      (z_nan_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: value-level normalize, round-half-even, classify and pack.
    function automatic void model(input logic s, input int e_in, input logic [27:0] m_in,
                                  input logic inf, input logic nan,
                                  output logic [31:0] z, output logic zi, output logic zn,
                                  output int lat);
        int  m;
        int  e;
        int  k;
        int  sig;
        int  grs;
        bit  hid;
        m = int'(m_in);
        e = e_in;
        k = 0;
        zi = 1'b0;
        zn = 1'b0;
        lat = 2;
        if (nan) begin
            z = 32'h7FC0_0000;
            zn = 1'b1;
            return;
        end
        if (inf) begin
            z = {s, 8'hFF, 23'h0};
            zi = 1'b1;
            return;
        end
        if (m == 0) begin
            z = {s, 31'h0};
            return;
        end
        while (1) begin
            if (m >= (1 << 27) || (SUB && e < 1)) begin
                m = (m >> 1) | (m & 1);
                e++;
                k++;
            end else if (m < (1 << 26) && e > 1) begin
                m = m << 1;
                e--;
                k++;
            end else begin
                break;
            end
        end
        lat = 3 + k;
        hid = (m >= (1 << 26));
        sig = m >> 3;
        grs = m & 7;
        if (grs > 4 || (grs == 4 && (sig & 1) == 1)) sig++;
        if (sig >= (1 << 24)) begin
            sig = sig >> 1;
            e++;
        end
        if (e >= 255) begin
            z = {s, 8'hFF, 23'h0};
            zi = 1'b1;
        end else if (e < 1 || !hid) begin
            z = SUB ? {s, 31'(sig)} : {s, 31'h0};
        end else begin
            z = {s, 8'(e), 23'(sig)};
        end
    endfunction

    // Issue one request, optionally holding valid high with junk while busy.
    task automatic run_op(input string tag, input logic s, input int e, input logic [27:0] m,
                          input logic inf, input logic nan, input logic hold,
                          output logic [31:0] z_obs, output int lat_obs);
        logic [31:0] z_exp;
        logic        zi_exp;
        logic        zn_exp;
        int          lat_exp;
        int          cyc;
        bit          seen;
        model(s, e, m, inf, nan, z_exp, zi_exp, zn_exp, lat_exp);
        sign_i = s;
        exp_i = 10'(e);
        mant_i = m;
        infinity_i = inf;
        nan_i = nan;
        data_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        if (hold) begin
            sign_i = ~s;
            exp_i = 10'($urandom());
            mant_i = 28'($urandom());
            infinity_i = 1'($urandom_range(0, 1));
            nan_i = 1'($urandom_range(0, 1));
        end else begin
            data_valid_i = 1'b0;
        end
        check({tag, "/busy_accept"}, 32'(busy_o), 32'(1));
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 64) begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (data_ready_o) seen = 1'b1;
        end
        data_valid_i = 1'b0;
        check({tag, "/ready_seen"}, 32'(seen), 32'(1));
        check({tag, "/latency"}, 32'(cyc), 32'(lat_exp));
        check({tag, "/z"}, z_o, z_exp);
        check({tag, "/z_inf"}, 32'(z_infinity_o), 32'(zi_exp));
        check({tag, "/z_nan"}, 32'(z_nan_o), 32'(zn_exp));
        check({tag, "/busy_done"}, 32'(busy_o), 32'(0));
        z_obs = z_o;
        lat_obs = cyc;
        @(posedge clk_i);
        #1;
        check({tag, "/ready_pulse"}, 32'(data_ready_o), 32'(0));
        check({tag, "/idle_after"}, 32'(busy_o), 32'(0));
    endtask

    initial begin
        logic [31:0] zo;
        int          lat;
        bit          pulse;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst/z", z_o, 32'h0);
        check("rst/ready", 32'(data_ready_o), 32'(0));
        check("rst/busy", 32'(busy_o), 32'(0));
        check("rst/z_inf", 32'(z_infinity_o), 32'(0));
        check("rst/z_nan", 32'(z_nan_o), 32'(0));
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        run_op("plain", 1'b0, 127, 28'h600_0000, 1'b0, 1'b0, 1'b0, zo, lat);
        check("plain/z_const", zo, 32'h3FC0_0000);
        check("plain/lat_const", 32'(lat), 32'(3));

        run_op("carry", 1'b0, 127, 28'h800_0000, 1'b0, 1'b0, 1'b1, zo, lat);
        check("carry/z_const", zo, 32'h4000_0000);
        check("carry/lat_const", 32'(lat), 32'(4));

        run_op("lnorm", 1'b0, 130, 28'h100_0000, 1'b0, 1'b0, 1'b0, zo, lat);
        check("lnorm/z_const", zo, 32'h4000_0000);
        check("lnorm/lat_const", 32'(lat), 32'(5));

        run_op("rnd_up", 1'b0, 127, 28'h400_0007, 1'b0, 1'b0, 1'b0, zo, lat);
        check("rnd_up/z_const", zo, 32'h3F80_0001);

        run_op("rnd_tie", 1'b0, 127, 28'h400_0004, 1'b0, 1'b0, 1'b0, zo, lat);
        check("rnd_tie/z_const", zo, 32'h3F80_0000);

        run_op("ovf", 1'b0, 254, 28'h800_0000, 1'b0, 1'b0, 1'b0, zo, lat);
        check("ovf/z_const", zo, 32'h7F80_0000);
        check("ovf/flag_const", 32'(z_infinity_o), 32'(1));

        run_op("nan", 1'b0, 127, 28'h400_0000, 1'b1, 1'b1, 1'b0, zo, lat);
        check("nan/z_const", zo, 32'h7FC0_0000);
        check("nan/flag_const", 32'(z_nan_o), 32'(1));

        run_op("neg_zero", 1'b1, 127, 28'h0, 1'b0, 1'b0, 1'b0, zo, lat);
        check("neg_zero/z_const", zo, 32'h8000_0000);
        check("neg_zero/lat_const", 32'(lat), 32'(2));
        check("neg_zero/nan_cleared", 32'(z_nan_o), 32'(0));

        run_op("subn", 1'b0, 1, 28'h200_0000, 1'b0, 1'b0, 1'b0, zo, lat);
        check("subn/z_const", zo, SUB ? 32'h0040_0000 : 32'h0000_0000);

        // Put a nonzero result on z_o, then reset in the middle of NORM.
        run_op("pre_rst", 1'b0, 127, 28'h600_0000, 1'b0, 1'b0, 1'b0, zo, lat);
        sign_i = 1'b0;
        exp_i = 10'd130;
        mant_i = 28'h000_0001;
        infinity_i = 1'b0;
        nan_i = 1'b0;
        data_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        data_valid_i = 1'b0;
        pulse = 1'b0;
        repeat (3) begin
            @(posedge clk_i);
            #1;
            if (data_ready_o) pulse = 1'b1;
        end
        check("mid_rst/busy_before", 32'(busy_o), 32'(1));
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        check("mid_rst/z", z_o, 32'h0);
        check("mid_rst/busy", 32'(busy_o), 32'(0));
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (data_ready_o) pulse = 1'b1;
        end
        check("mid_rst/no_ready", 32'(pulse), 32'(0));

        for (int i = 0; i < 300; i++) begin
            logic [27:0] m;
            int          e;
            logic        s;
            logic        nn;
            logic        ii;
            logic        hold;
            s = 1'($urandom_range(0, 1));
            e = int'($urandom_range(0, 300)) - 20;
            case ($urandom_range(0, 3))
                0: e = int'($urandom_range(248, 258));
                1: e = int'($urandom_range(0, 4)) - 2;
                default: ;
            endcase
            case ($urandom_range(0, 4))
                0: m = 28'($urandom());
                1: m = 28'($urandom()) >> $urandom_range(1, 27);
                2: m = {2'b01, 26'($urandom())};
                3: m = {2'b01, 23'($urandom()), 3'b100};
                default: m = ($urandom_range(0, 7) == 0) ? 28'h0 : {1'b1, 27'($urandom())};
            endcase
            nn = ($urandom_range(0, 15) == 0);
            ii = ($urandom_range(0, 15) == 0);
            hold = ($urandom_range(0, 3) == 0);
            run_op("rand", s, e, m, ii, nn, hold, zo, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_packer.md
# fp_packer

Back end of the floating-point datapath. Accepts an unnormalized result as sign, extended exponent and extended mantissa with guard/round/sticky bits from the arithmetic units. Normalizes it iteratively, rounds to nearest-even and packs it into an IEEE-754 single-precision word. It is the inverse of the operand decomposition stage: that stage splits words into fields, this block recomposes fields into a word.

## Interface
- No parameters; all widths come from `fpu_pkg`.
- `clk_i` in 1: clock; all logic on the rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `data_valid_i` in 1: input fields are valid; sampled only in IDLE.
- `sign_i` in 1: result sign.
- `exp_i` in 10: signed biased exponent, two's complement, range −512..511.
- `mant_i` in 28: extended mantissa.
  - bit 27: carry.
  - bit 26: hidden one.
  - bits 25:3: fraction.
  - bit 2: guard; bit 1: round; bit 0: sticky.
- `infinity_i` in 1: force a signed infinity result.
- `nan_i` in 1: force a NaN result; takes priority over `infinity_i`.
- `data_ready_o` out 1: one-cycle pulse when `z_o` is updated.
- `busy_o` out 1: high from the accept cycle until the DONE state is left.
- `z_o` out 32: packed result.
- `z_infinity_o` out 1: result is ±infinity.
- `z_nan_o` out 1: result is NaN.

## Operation
States: IDLE → LOAD → NORM → ROUND → DONE → IDLE.
- **IDLE**
  - If `data_valid_i` is high, register all inputs and go to LOAD.
  - Otherwise hold.
- **LOAD**
  - If `nan_i`: go to DONE, `z_o`=0x7FC00000.
  - Else if `infinity_i`: go to DONE, `z_o`={sign,0xFF,0}.
  - Else if mant==0: go to DONE, `z_o`={sign,31'h0}.
  - Otherwise go to NORM.
- **NORM** (one action per cycle)
  - If bit27 is set: shift mant right 1, OR the bit shifted out into sticky, exp+1.
  - Else if bit26 is clear and exp>1: shift mant left 1, exp−1.
  - Otherwise go to ROUND.
- **ROUND**
  - Round to nearest-even: increment fraction+hidden when G & (R | S | LSB), where LSB is bit 3.
  - If the increment carries into bit27: shift right 1, exp+1.
  - Then classify:
    - exp≥255: overflow, `z_o`={sign,0xFF,0}, `z_infinity_o`=1.
    - exp<1 or bit26 clear after NORM: underflow, handled per Configuration.
    - Otherwise: `z_o`={sign,exp[7:0],mant[25:3]}.
  - Go to DONE.
- **DONE**
  - Pulse `data_ready_o` and go to IDLE.
  - `z_o` and flags hold until the next LOAD-time or ROUND-time update.
- Outputs register in the cycle they are decided. Flags are cleared on each accept.
- `data_valid_i` is ignored while `busy_o` is high. A new request is accepted in the same cycle DONE returns to IDLE only if it is still asserted in IDLE.
- Reset is honoured in any state, including mid-NORM: the state returns to IDLE and the in-flight result is discarded without a `data_ready_o` pulse.

## Timing
- Reset values: `z_o`=0, `data_ready_o`=0, `busy_o`=0, `z_infinity_o`=0, `z_nan_o`=0, state IDLE.
- Latency is counted from the accept edge to the edge that raises `data_ready_o`.
  - Special cases (NaN, infinity, zero): 2 cycles.
  - Normal path: 3 + k cycles, where k is the number of NORM shifts. k ≤ 26 left shifts, or 1 right shift.
- A right shift never precedes a left shift within one operation.
- The post-round carry adds no cycle.

## Configuration
- `FPU_SUBNORMAL_EN` defined:
  - If NORM stops at exp==1 with bit26 clear, pack exponent field 0 and fraction mant[25:3] (subnormal).
  - If exp<1 arrives from the input, first shift right 1 per cycle in NORM until exp==1, accumulating sticky.
- Undefined: every underflow flushes to {sign,31'h0}; no extra cycles.

## Structure
- `fpu_pkg` holds:
  - widths `EXP_W`=8, `FRAC_W`=23, `MANT_X_W`=28.
  - `BIAS`=127, `EXP_MAX`=255.
  - constant `QNAN`=32'h7FC00000.
  - state enum `packer_state_t`.
- One sub-module, `fp_rounder`: combinational round-to-nearest-even with carry-out.

## Test plan
- Plain value: sign 0, exp 127, mant 0x6000000 → `z_o`=0x3FC00000 (1.5); `data_ready_o` 3 cycles after accept.
- Carry: exp 127, mant 0x8000000 → one right shift, `z_o`=0x40000000; latency 4.
- Left normalization: exp 130, mant 0x1000000 → two left shifts, `z_o`=0x40000000; latency 5.
- Rounding:
  - exp 127, mant 0x4000007 → round up, `z_o`=0x3F800001.
  - exp 127, mant 0x4000004 (tie, even LSB) → `z_o`=0x3F800000.
- Specials:
  - exp 254, mant 0x8000000 → `z_o`=0x7F800000, `z_infinity_o`=1.
  - `nan_i` → `z_o`=0x7FC00000, `z_nan_o`=1.
  - sign 1, mant 0 → `z_o`=0x80000000; latency 2.
- Reset and underflow:
  - Assert `rst_i`=0 during NORM of an exp-130, mant-0x0000001 request → IDLE, no `data_ready_o` pulse, `z_o`=0.
  - Exp 1, mant 0x2000000 → `z_o`=0x00400000 with `FPU_SUBNORMAL_EN` defined, 0x00000000 without it.
